// File: rtl/clk_gen_if.sv
// ---------------------------------------------------------------------------
// clk_gen_if
// Reconfiguration request channel for clk_gen. A requester raises cfg_valid
// with a target channel and divide value and holds them until cfg_ready.
//
// Signals:
//   cfg_valid  requester -> clk_gen   reconfiguration request
//   cfg_ready  clk_gen -> requester   request accepted this cycle when high
//   cfg_ch     requester -> clk_gen   target channel index
//   cfg_div    requester -> clk_gen   new divide value D (0 disables)
//   cfg_phase  requester -> clk_gen   start count for the new divider,
//                                     present only with CLK_GEN_PHASE_EN
//
// Optional feature macro: CLK_GEN_PHASE_EN
// ---------------------------------------------------------------------------
interface clk_gen_if #(
    parameter int NCH  = 2,
    parameter int DIVW = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [DIVW-1:0] cfg_div;
`ifdef CLK_GEN_PHASE_EN
    logic [DIVW-1:0] cfg_phase;
`endif

    modport master (
`ifdef CLK_GEN_PHASE_EN
        output cfg_phase,
`endif
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
`ifdef CLK_GEN_PHASE_EN
        input  cfg_phase,
`endif
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_gen.sv
// ---------------------------------------------------------------------------
// clk_gen
// Multi-channel programmable clock-enable / divided-clock generator running
// entirely in the inclk0 domain. Each channel counts 0..D-1 and produces a
// one-cycle ce pulse plus a 50% duty divided clock c of period 2*D. Divide
// values can be changed at run time, one channel at a time, without glitching
// the other channels; the new value is applied at the target's next wrap.
//
// Ports:
//   inclk0   input          single clock
//   rst      input          synchronous active-high reset
//   cfg      clk_gen_if     reconfiguration handshake (slave side)
//   ce       output [NCH]   per-channel one-cycle clock-enable pulse
//   c        output [NCH]   per-channel divided clock
//   locked   output         all channels stable and configuration idle
//
// Optional feature macro: CLK_GEN_PHASE_EN adds cfg_phase, used as the start
// count of the reconfigured channel (ignored when not below the new D).
// ---------------------------------------------------------------------------
module clk_gen #(
    parameter int NCH         = 2,
    parameter int DIVW        = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic           inclk0,
    input  logic           rst,
    clk_gen_if.slave       cfg,
    output logic [NCH-1:0] ce,
    output logic [NCH-1:0] c,
    output logic           locked
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CHW:0]    NCH_LIM   = (CHW + 1)'(NCH);
    localparam logic [DIVW-1:0] DIV_RST   = DIVW'(DEFAULT_DIV);
    localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        LOCKING,
        IDLE,
        PENDING
    } state_t;

    state_t          state_q, state_d;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;

    logic [CHW-1:0]  sh_ch_q, sh_ch_d;
    logic [DIVW-1:0] sh_div_q, sh_div_d;
`ifdef CLK_GEN_PHASE_EN
    logic [DIVW-1:0] sh_phase_q, sh_phase_d;
`endif

    logic [DIVW-1:0] div_q [NCH];
    logic [DIVW-1:0] div_d [NCH];
    logic [DIVW-1:0] cnt_q [NCH];
    logic [DIVW-1:0] cnt_d [NCH];
    logic [NCH-1:0]  ce_q, ce_d;
    logic [NCH-1:0]  c_q, c_d;

    logic [NCH-1:0]  wrap;
    logic            apply_now;
    logic [DIVW-1:0] start_cnt;

    // A channel wraps when its counter reaches D-1; disabled channels never wrap.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wrap[i] = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - 1'b1);
        end
    end

    // Count value the reconfigured channel restarts from.
`ifdef CLK_GEN_PHASE_EN
    assign start_cnt = (sh_phase_q < sh_div_q) ? sh_phase_q : '0;
`else
    assign start_cnt = '0;
`endif

    // Per-channel divider datapath. The target channel switches to the
    // shadow divide value on the cycle it would wrap anyway, so the period in
    // flight completes cleanly (its final ce pulse / c toggle still happens).
    always_comb begin
        apply_now = 1'b0;
        ce_d      = '0;
        c_d       = '0;
        for (int i = 0; i < NCH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = '0;
            if (div_q[i] != '0) begin
                cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + 1'b1;
                ce_d[i]  = wrap[i];
                c_d[i]   = c_q[i] ^ wrap[i];
            end
            if ((state_q == PENDING) && (sh_ch_q == CHW'(i)) &&
                ((div_q[i] == '0) || wrap[i])) begin
                apply_now = 1'b1;
                div_d[i]  = sh_div_q;
                if (sh_div_q == '0) begin
                    cnt_d[i] = '0;
                    ce_d[i]  = 1'b0;
                    c_d[i]   = 1'b0;
                end else begin
                    cnt_d[i] = start_cnt;
                end
            end
        end
    end

    // Control FSM: settle for LOCK_CYCLES, accept one request in IDLE, then
    // wait in PENDING until the target channel reaches a safe switch point.
    // Requests for channels that do not exist are consumed without effect.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        sh_ch_d    = sh_ch_q;
        sh_div_d   = sh_div_q;
`ifdef CLK_GEN_PHASE_EN
        sh_phase_d = sh_phase_q;
`endif
        case (state_q)
            LOCKING: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (cfg.cfg_valid && ({1'b0, cfg.cfg_ch} < NCH_LIM)) begin
                    sh_ch_d  = cfg.cfg_ch;
                    sh_div_d = cfg.cfg_div;
`ifdef CLK_GEN_PHASE_EN
                    sh_phase_d = cfg.cfg_phase;
`endif
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (apply_now) begin
                    state_d    = LOCKING;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = LOCKING;
                lock_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending request.
    always_ff @(posedge inclk0) begin
        if (rst) begin
            state_q    <= LOCKING;
            lock_cnt_q <= '0;
            sh_ch_q    <= '0;
            sh_div_q   <= '0;
`ifdef CLK_GEN_PHASE_EN
            sh_phase_q <= '0;
`endif
            ce_q       <= '0;
            c_q        <= '0;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            sh_ch_q    <= sh_ch_d;
            sh_div_q   <= sh_div_d;
`ifdef CLK_GEN_PHASE_EN
            sh_phase_q <= sh_phase_d;
`endif
            ce_q       <= ce_d;
            c_q        <= c_d;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign locked        = (state_q == IDLE);
    assign ce            = ce_q;
    assign c             = c_q;
endmodule

// File: doc/clk_gen.md
CLK_GEN -- requirements
Module: clk_gen

Interface
REQ-001 SHALL have parameter NCH, default 2: number of output clock channels (1..8).
REQ-002 SHALL have parameter DIVW, default 8: divider/phase field width.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2: divide value loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16: settle time, in inclk0 cycles, before locked asserts.
REQ-005 SHALL have port inclk0  input  1: single clock; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port rst  input  1: synchronous active-high reset.
REQ-007 SHALL have port cfg_valid  input  1: reconfiguration request.
REQ-008 SHALL have port cfg_ready  output  1: reconfiguration accepted when high with cfg_valid.
REQ-009 SHALL have port cfg_ch  input  max(1,clog2(NCH)): target channel.
REQ-010 SHALL have port cfg_div  input  DIVW: new divide value D.
REQ-011 SHALL have port ce  output  NCH: per-channel one-cycle clock-enable pulse.
REQ-012 SHALL have port c  output  NCH: per-channel divided clock, period 2*D.
REQ-013 SHALL have port locked  output  1: all channels stable, configuration idle.

Function
REQ-014 SHALL keep per channel a DIVW-bit counter cnt running 0..D-1, wrapping to 0 after D-1.
REQ-015 SHALL register ce[i] high for exactly the one cycle following cnt==D-1; D=1 gives ce[i] constantly high.
REQ-016 SHALL toggle c[i] in that same registered cycle as each ce[i] pulse, giving a 50% duty cycle with period 2*D.
REQ-017 SHALL treat D=0 as channel disabled: cnt held 0, ce[i]=0, c[i]=0.
REQ-018 SHALL implement FSM states LOCKING, IDLE, PENDING; cfg_ready=1 only in IDLE; locked=1 only in IDLE.
REQ-019 SHALL in LOCKING count LOCK_CYCLES cycles, then move to IDLE.
REQ-020 SHALL on cfg_valid&&cfg_ready with cfg_ch<NCH latch cfg_ch/cfg_div into a shadow register and move to PENDING next cycle.
REQ-021 SHALL on handshake with cfg_ch>=NCH consume the request, change nothing, and remain in IDLE.
REQ-022 SHALL in PENDING apply the shadow D to the target channel in the cycle its cnt==D_old-1 (or immediately if D_old=0), restart its cnt, force c to 0 if new D=0, then enter LOCKING.
REQ-023 SHALL leave non-target channels running uninterrupted across any reconfiguration.
REQ-024 SHALL ignore cfg_valid outside IDLE; the requester must hold cfg_valid until cfg_ready.

Reset
REQ-025 SHALL on rst clear all cnt, ce, c, set every D to DEFAULT_DIV, clear the shadow register, and enter LOCKING with cfg_ready=0 and locked=0.
REQ-026 SHALL let rst asserted in PENDING or LOCKING discard any pending configuration; rst has priority over any handshake in the same cycle.

Configuration
REQ-027 SHALL, when macro CLK_GEN_PHASE_EN is defined, add input cfg_phase (DIVW), latched with cfg_div, and on apply load cnt with cfg_phase if cfg_phase<D, else 0.
REQ-028 SHALL, without CLK_GEN_PHASE_EN, omit port cfg_phase and always restart cnt at 0 on apply.

Verification
REQ-029 SHALL cover reset: rst 1 cycle, defaults -> c[0],c[1] period 4 cycles, locked rises exactly 16 cycles after rst deasserts, cfg_ready=0 meanwhile.
REQ-030 SHALL cover reconfiguration: cfg_ch=1, cfg_div=5 in IDLE -> ch1 switches at its next wrap to period 10, ce[1] every 5 cycles, ch0 unchanged, locked low 16+ cycles.
REQ-031 SHALL cover disable/re-enable: cfg_div=0 on ch0 -> c[0]=0, ce[0]=0; then cfg_div=1 -> ce[0] constantly high, c[0] toggling every cycle.
REQ-032 SHALL cover invalid channel: cfg_ch=3 with NCH=2 -> handshake completes, FSM stays IDLE, locked stays 1, outputs unchanged.
REQ-033 SHALL cover reset mid-PENDING: cfg_div=7 accepted, rst next cycle -> both channels back to D=2, shadow discarded.
REQ-034 SHALL cover phase, with CLK_GEN_PHASE_EN: cfg_div=4, cfg_phase=2 on ch0 -> first ce[0] pulse 2 cycles after apply, thereafter every 4; cfg_phase=9 -> cnt starts at 0.
